// File: rtl/mult128_issue_if.sv
// ============================================================================
// mult128_issue_if : operand/result handshake and multiplier bus bundle
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mult128_issue_if #(
  parameter int W = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_data;
  logic             busy;
  logic             ovf_err;
`ifdef MULT128_TAG_EN
  logic [7:0]       in_tag;
  logic [7:0]       out_tag;
`endif

  // Controller side
  modport slave (
    input  in_valid, in_a, in_b, mul_result, out_ready,
`ifdef MULT128_TAG_EN
    input  in_tag,
    output out_tag,
`endif
    output in_ready, mul_a, mul_b, out_valid, out_data, busy, ovf_err
  );

  // Producer / multiplier / consumer side
  modport master (
    output in_valid, in_a, in_b, mul_result, out_ready,
`ifdef MULT128_TAG_EN
    output in_tag,
    input  out_tag,
`endif
    input  in_ready, mul_a, mul_b, out_valid, out_data, busy, ovf_err
  );
endinterface

`default_nettype wire

// File: rtl/mult128_issue_ctrl.sv
// ============================================================================
// mult128_issue_ctrl : credit-based issue/collect controller for a fixed-
// latency 128x128 multiplier. Optional tag path: `define MULT128_TAG_EN
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mult128_issue_ctrl #(
  parameter int W     = 128,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mult128_issue_if.slave  io
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   c_OCC_MAX  = (CNT_W+1)'(DEPTH);

  logic [W-1:0]     r_mul_a;
  logic [W-1:0]     r_mul_b;
  logic [LAT:0]     r_vld_sr;
  logic [CNT_W-1:0] r_infl_cnt;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2*W-1:0]   r_mem [DEPTH];
  logic             r_ovf_err;

  logic [CNT_W:0]   w_occ;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic             w_full;

  // Credits count both in-flight and stored products, from registered state only
  always_comb begin
    w_occ       = {1'b0, r_infl_cnt} + {1'b0, r_fifo_cnt};
    w_in_ready  = ~reset & (w_occ < c_OCC_MAX);
    w_accept    = io.in_valid & w_in_ready;
    w_push      = r_vld_sr[LAT];
    w_out_valid = (r_fifo_cnt != '0);
    w_pop       = w_out_valid & io.out_ready;
    w_full      = (r_fifo_cnt == c_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_vld_sr   <= '0;
      r_infl_cnt <= '0;
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mul_a <= io.in_a;
        r_mul_b <= io.in_b;
      end
      r_vld_sr <= {r_vld_sr[LAT-1:0], w_accept};

      case ({w_accept, w_push})
        2'b10:   r_infl_cnt <= r_infl_cnt + 1'b1;
        2'b01:   r_infl_cnt <= r_infl_cnt - 1'b1;
        default: r_infl_cnt <= r_infl_cnt;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_push && w_full && !w_pop) r_ovf_err <= 1'b1;
    end
  end

  // Product storage carries no reset; the head is masked until the count says valid
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= io.mul_result;
  end

  assign io.in_ready  = w_in_ready;
  assign io.mul_a     = r_mul_a;
  assign io.mul_b     = r_mul_b;
  assign io.out_valid = w_out_valid;
  assign io.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign io.busy      = (w_occ != '0);
  assign io.ovf_err   = r_ovf_err;

`ifdef MULT128_TAG_EN
  logic [LAT:0][7:0] r_tag_sr;
  logic [7:0]        r_tag_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_sr <= '0;
    end else begin
      r_tag_sr <= {r_tag_sr[LAT-1:0], (w_accept ? io.in_tag : 8'h00)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_tag_mem[r_wr_ptr] <= r_tag_sr[LAT];
  end

  assign io.out_tag = w_out_valid ? r_tag_mem[r_rd_ptr] : 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult128_issue_ctrl.sv
// ============================================================================
// tb_mult128_issue_ctrl : directed vector bench with a 4-stage multiplier model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mult128_issue_ctrl;

  localparam int W     = 128;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int NV    = 16;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] P127 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] P64  = 128'h1_0000_0000_0000_0000;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [7:0]   tag;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [NV];

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mult128_issue_if #(.W(W)) v();

  mult128_issue_ctrl #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (v)
  );

  always #5 clk = ~clk;

  // Multiplier: product of operands stable after edge k is on mul_result after edge k+LAT
  logic [2*W-1:0] mstage [LAT];
  always_ff @(posedge clk) begin
    mstage[0] <= {128'd0, v.mul_a} * {128'd0, v.mul_b};
    for (int s = 1; s < LAT; s++) mstage[s] <= mstage[s-1];
  end
  assign v.mul_result = mstage[LAT-1];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [127:0] a, input logic [127:0] b,
                      input logic [7:0] tag, input logic [255:0] exp);
    tbl[i].a = a; tbl[i].b = b; tbl[i].tag = tag; tbl[i].exp = exp;
  endtask

  // Offers table entries first..first+n-1, advancing only on accept
  task automatic produce(input int first, input int n, output int stalls);
    int  i;
    int  cyc;
    logic acc;
    i = first; cyc = 0; stalls = 0;
    while (i < first + n && cyc < 600) begin
      v.in_valid = 1'b1;
      v.in_a     = tbl[i].a;
      v.in_b     = tbl[i].b;
`ifdef MULT128_TAG_EN
      v.in_tag   = tbl[i].tag;
`endif
      @(negedge clk);
      acc = v.in_ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    v.in_valid = 1'b0;
    chk("produce_count", 256'(i), 256'(first + n));
  endtask

  // Checks results in order; strict demands no gap after the first result
  task automatic consume(input int first, input int n, input logic [3:0] pat, input bit strict);
    int i;
    int cyc;
    i = first; cyc = 0;
    while (i < first + n && cyc < 600) begin
      v.out_ready = pat[cyc % 4];
      @(negedge clk);
      if (v.out_valid && v.out_ready) begin
        chk($sformatf("out_data[%0d]", i), v.out_data, tbl[i].exp);
`ifdef MULT128_TAG_EN
        chk($sformatf("out_tag[%0d]", i), 256'(v.out_tag), 256'(tbl[i].tag));
`endif
        i++;
      end else if (strict && i > first) begin
        chk($sformatf("stream_gap[%0d]", i), 256'(v.out_valid), 256'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    v.out_ready = 1'b0;
    chk("consume_count", 256'(i), 256'(first + n));
  endtask

  initial begin
    int st;
    int cnt;
    int extra;

    setv(0,  ONES, ONES, 8'hA1, {ONES - 128'd1, 128'd1});
    setv(1,  P127, 128'd2, 8'hA2, {128'd1, 128'd0});
    setv(2,  128'd0, ONES, 8'hA3, 256'd0);
    setv(3,  128'd1, ONES, 8'h04, {128'd0, ONES});
    setv(4,  P64, P64, 8'h05, {128'd1, 128'd0});
    setv(5,  ONES, 128'd2, 8'h06, {128'd1, ONES - 128'd1});
    setv(6,  P127, P127, 8'h07, {128'h4000_0000_0000_0000_0000_0000_0000_0000, 128'd0});
    setv(7,  128'h1_0000_0001, 128'h1_0000_0001, 8'h08, {128'd0, 128'h1_0000_0002_0000_0001});
    setv(8,  128'd12345, 128'd1000, 8'h09, 256'd12345000);
    setv(9,  128'h10_0000_0000_0000_0000_0000_0000, 128'h800_0000, 8'h0A, {128'd0, P127});
    setv(10, ONES, 128'd1, 8'h0B, {128'd0, ONES});
    setv(11, 128'h1_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000_0000_0000, 8'h0C,
             {P64, 128'd0});
    setv(12, 128'd3, 128'd5, 8'h0D, 256'd15);
    setv(13, 128'd65535, 128'd65535, 8'h0E, 256'hFFFE0001);
    setv(14, P127, ONES, 8'h0F, {ONES >> 1, P127});
    setv(15, 128'd7, 128'd9, 8'h10, 256'd63);

    reset = 1'b1;
    v.in_valid = 1'b0; v.in_a = '0; v.in_b = '0; v.out_ready = 1'b0;
`ifdef MULT128_TAG_EN
    v.in_tag = 8'h00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 256'(v.in_ready), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 256'(v.in_ready), 256'd1);
    chk("rst_out_valid", 256'(v.out_valid), 256'd0);
    chk("rst_busy", 256'(v.busy), 256'd0);
    chk("rst_ovf", 256'(v.ovf_err), 256'd0);
    chk("rst_mul_a", 256'(v.mul_a), 256'd0);
    chk("rst_mul_b", 256'(v.mul_b), 256'd0);
    chk("rst_out_data", v.out_data, 256'd0);
`ifdef MULT128_TAG_EN
    chk("rst_out_tag", 256'(v.out_tag), 256'd0);
`endif
    @(posedge clk); #1;

    // Single op: latency LAT+1 edges from accept to out_valid
    v.in_valid = 1'b1; v.in_a = 128'd3; v.in_b = 128'd5; v.out_ready = 1'b1;
    @(negedge clk);
    chk("single_in_ready", 256'(v.in_ready), 256'd1);
    @(posedge clk); #1;
    v.in_valid = 1'b0;
    chk("single_mul_a", 256'(v.mul_a), 256'd3);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (v.out_valid) break;
      @(posedge clk); #1;
      cnt++;
    end
    chk("single_latency", 256'(cnt), 256'(LAT + 1));
    chk("single_data", v.out_data, 256'd15);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_busy_fall", 256'(v.busy), 256'd0);
    chk("single_out_valid_fall", 256'(v.out_valid), 256'd0);
    @(posedge clk); #1;

    // Back-to-back streaming with out_ready held high
    fork
      produce(0, NV, st);
      consume(0, NV, 4'b1111, 1'b1);
    join
    chk("stream_no_stall", 256'(st), 256'd0);

    // Backpressure: exactly DEPTH accepts, then credits exhausted
    v.out_ready = 1'b0;
    produce(0, DEPTH, st);
    extra = 0;
    v.in_valid = 1'b1; v.in_a = tbl[8].a; v.in_b = tbl[8].b;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (v.in_ready) extra++;
      @(posedge clk); #1;
    end
    v.in_valid = 1'b0;
    chk("bp_extra_accepts", 256'(extra), 256'd0);
    @(negedge clk);
    chk("bp_out_valid", 256'(v.out_valid), 256'd1);
    chk("bp_busy", 256'(v.busy), 256'd1);
    chk("bp_ovf", 256'(v.ovf_err), 256'd0);
    chk("bp_head", v.out_data, tbl[0].exp);
    @(posedge clk); #1;
    consume(0, DEPTH, 4'b1111, 1'b1);
    @(negedge clk);
    chk("bp_resume_ready", 256'(v.in_ready), 256'd1);
    chk("bp_drained_busy", 256'(v.busy), 256'd0);
    @(posedge clk); #1;

    // Fill to full, then drain while refilling: pointers wrap at high occupancy
    fork
      produce(0, NV, st);
      begin
        v.out_ready = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        consume(0, NV, 4'b1111, 1'b0);
      end
    join
    chk("churn_ovf", 256'(v.ovf_err), 256'd0);

    // Irregular consumer stalls; tags must stay aligned with products
    fork
      produce(0, 3, st);
      consume(0, 3, 4'b0110, 1'b0);
    join
    fork
      produce(3, 10, st);
      consume(3, 10, 4'b1001, 1'b0);
    join

    // Reset with 2 stored and 3 in flight
    v.out_ready = 1'b0;
    produce(0, 2, st);
    repeat (6) @(posedge clk);
    #1;
    produce(2, 3, st);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 256'(v.out_valid), 256'd0);
    chk("mid_rst_busy", 256'(v.busy), 256'd0);
    chk("mid_rst_in_ready", 256'(v.in_ready), 256'd1);
    chk("mid_rst_out_data", v.out_data, 256'd0);
    @(posedge clk); #1;
    v.out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v.out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_stale", 256'(cnt), 256'd0);
    fork
      produce(12, 1, st);
      consume(12, 1, 4'b1111, 1'b0);
    join
    chk("final_ovf", 256'(v.ovf_err), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult128_issue_ctrl.md
Name: mult128_issue_ctrl

Overview:
- Credit-based issue/collect controller for the 128x128 Karatsuba multiplier.
- Accepts operand pairs on a valid/ready interface and registers them onto the multiplier operand bus.
- Tracks each product through the multiplier's fixed latency and captures it into a result FIFO.
- Presents results on a valid/ready output, so downstream backpressure never drops a product from the non-stallable multiplier pipe.

Parameters:
- W, 128, operand width; products are 2*W.
- LAT, 4, multiplier latency in clock edges, from operands stable on mul_a/mul_b to product stable on mul_result.
- DEPTH, 8, result FIFO depth; also the maximum credits (in-flight + stored). Power of 2, DEPTH >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a  in  W  operand A
- in_b  in  W  operand B
- mul_a  out  W  registered operand A to multiplier
- mul_b  out  W  registered operand B to multiplier
- mul_result  in  2*W  product from multiplier
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  2*W  product, FIFO head
- busy  out  1  any product in flight or stored
- ovf_err  out  1  sticky: FIFO push while full (must never fire)

Behaviour:
- Reset (sampled high at an edge) zeroes the following:
  - mul_a and mul_b
  - in-flight shift register and in-flight count
  - FIFO pointers and count
  - out_valid, out_data, busy and ovf_err
- in_ready is forced 0 while reset is high.
- Credits: occ = inflight_cnt + fifo_cnt. in_ready = (occ < DEPTH) and has no combinational dependence on in_valid or out_ready.
- A pop in the same cycle does not free a credit until the next cycle.
- Issue (accept at edge k):
  - mul_a/mul_b load in_a/in_b at edge k.
  - A 1 enters the valid shift register (length LAT+1); inflight_cnt increments.
  - When idle, mul_a/mul_b hold their last value.
- Capture:
  - At edge k+LAT+1 the shift register output is 1; mul_result is written to the FIFO tail and inflight_cnt decrements.
  - Accept and capture in the same edge leave inflight_cnt unchanged.
- Output:
  - out_valid = (fifo_cnt != 0); out_data = FIFO head, combinational from storage.
  - Pop on out_valid & out_ready.
  - Accept-to-out_valid latency is LAT+1 edges with an empty FIFO.
- Throughput:
  - One product per cycle sustained when out_ready=1 and DEPTH >= LAT+2.
  - Otherwise bounded by credits.
- FIFO:
  - Circular pointers of log2(DEPTH) bits wrap naturally.
  - Push and pop in the same edge with fifo_cnt==DEPTH is legal (count unchanged).
  - Push and pop with fifo_cnt==0 is also legal: the pushed entry becomes the head next cycle, with no bypass.
- ovf_err sets if a push occurs with fifo_cnt==DEPTH and no pop. It clears only on reset.
- Order: results leave strictly in acceptance order.
- Reset mid-operation drops all in-flight and stored products. Late mul_result values are ignored because the shift register is cleared.
- busy = (occ != 0).

Optional Feature:
- Macro: MULT128_TAG_EN.
- Defined:
  - Adds ports in_tag (in, 8) and out_tag (out, 8).
  - The tag travels with the valid bit through an 8-bit-wide LAT+1 shift register and is stored in the FIFO beside the product.
  - out_tag is aligned with out_data; reset value 0.
- Undefined:
  - No tag ports and no tag storage.
  - Behaviour is otherwise identical.

Test Plan:
- Single op: A=3, B=5, out_ready=1 -> out_valid exactly LAT+1 cycles after accept, out_data=15, busy falls the next cycle.
- Full-width streaming: 16 back-to-back pairs A=B=2^128-1, then A=2^127, B=2 and others, out_ready=1 -> one result per cycle in order, first = 2^256-2^129+1; in_ready stays 1.
- Backpressure: out_ready=0, in_valid=1 held -> exactly DEPTH=8 accepts, then in_ready=0. fifo_cnt reaches 8 with no ovf_err. Raise out_ready -> 8 results in order, then accepts resume.
- Simultaneous push/pop at full: FIFO full, out_ready=1 with one capture arriving in the same edge -> fifo_cnt stays 8, no data loss, pointers wrap correctly.
- Reset mid-flight: 3 ops in flight plus 2 stored, assert reset for 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1; no stale product ever appears.
- MULT128_TAG_EN: tags 0xA1, 0xA2, 0xA3 with varied out_ready stalls -> out_tag matches each product in order.
